// File: rtl/stream_arbiter_rr.sv
// stream_arbiter_rr
//
// Round-robin arbiter that merges NumReq upstream valid/ready streams into one
// registered downstream stream. A requester that starts a multi-beat packet
// (first beat with last=0) keeps the grant until its last beat is accepted,
// so packets from different sources are never interleaved. The rotating
// priority pointer moves past the source of every accepted beat.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester valid
//   req_last_i   per-requester last-beat flag (only meaningful with valid)
//   req_data_i   flattened data, requester i at [i*DataWidth +: DataWidth]
//   req_ready_o  per-requester ready, at most one bit set
//   gnt_o        combinational one-hot grant, zero when nothing is granted
//   out_valid_o  output stage holds a beat
//   out_ready_i  downstream accepts the held beat
//   out_data_o   registered beat data
//   out_last_o   registered last flag
//   out_src_o    registered index of the requester that produced the beat

module stream_arbiter_rr #(
    parameter int DataWidth = 32,
    parameter int NumReq    = 4,
    localparam int SrcWidth = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq-1:0]             req_last_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             gnt_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [SrcWidth-1:0]           out_src_o
);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e                state_q, state_d;
    logic [SrcWidth-1:0]   owner_q, owner_d;
    logic [SrcWidth-1:0]   ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [SrcWidth-1:0]   out_src_q, out_src_d;

    logic                  win_found;
    logic [SrcWidth-1:0]   win_idx;
    int                    cand_int;
    logic [SrcWidth-1:0]   cand;
    logic                  gnt_any;
    logic [SrcWidth-1:0]   gnt_idx;
    logic [NumReq-1:0]     gnt;
    logic                  load_en;
    logic                  accept;
    logic [DataWidth-1:0]  sel_data;
    logic                  sel_last;

    // The output register can take a new beat whenever it is empty or is
    // being drained this very cycle, which gives back-to-back throughput.
    assign load_en = !out_valid_q || out_ready_i;

    // Rotating priority search: walk ptr, ptr+1, ... wrapping at NumReq (which
    // need not be a power of two, hence the explicit wrap) and keep the first
    // valid requester found.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_int  = 0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand_int = int'(ptr_q) + k;
            if (cand_int >= NumReq) begin
                cand_int = cand_int - NumReq;
            end
            cand = SrcWidth'(cand_int);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // While a packet is open the owner holds the grant even if it has dropped
    // valid for a while; everyone else simply waits.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_q == ST_LOCKED) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
        end else begin
            gnt_any = win_found;
            gnt_idx = win_idx;
        end
    end

    // Expand the granted index into a one-hot vector and use it to pick the
    // winner's data and last flag with an AND-OR mux over the flat bus.
    always_comb begin
        gnt      = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            gnt[i] = gnt_any && (gnt_idx == SrcWidth'(i));
            if (gnt[i]) begin
                sel_data = sel_data | req_data_i[i*DataWidth +: DataWidth];
                sel_last = sel_last | req_last_i[i];
            end
        end
    end

    assign gnt_o       = gnt;
    assign req_ready_o = gnt & {NumReq{load_en}};
    assign accept      = |(req_valid_i & req_ready_o);

    // Next-state logic. An accepted beat loads the output stage, advances the
    // pointer past its source and opens or closes the packet lock; otherwise a
    // drained output simply goes empty while keeping its last contents.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = gnt_idx;
            if (gnt_idx == SrcWidth'(NumReq - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + SrcWidth'(1);
            end
            if (sel_last) begin
                state_d = ST_ARB;
            end else begin
                state_d = ST_LOCKED;
                owner_d = gnt_idx;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // All state lives here; reset wins over everything and silently abandons
    // any packet that was in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ARB;
            owner_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;

endmodule

// File: doc/stream_arbiter_rr.md
Name: stream_arbiter_rr

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream between NumReq upstream requesters.
- Produces a one-hot grant that selects the winner's data from a flattened input bus, in the same flat packing used by the one-hot mux utility.
- Registers the result into a single output stage.
- Supports multi-beat packets: a requester that starts a packet keeps the grant until its last beat is accepted.

Parameters:
- DataWidth, 32, width of one requester's data word.
- NumReq, 4, number of requesters; legal values 2..32.
- SrcWidth, $clog2(NumReq), width of the source-index output; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  NumReq  per-requester valid.
- req_last_i  input  NumReq  per-requester last-beat flag; meaningful only with the matching valid.
- req_data_i  input  NumReq*DataWidth  flattened data; requester i occupies bits [i*DataWidth +: DataWidth].
- req_ready_o  output  NumReq  per-requester ready; at most one bit set.
- gnt_o  output  NumReq  current-cycle one-hot grant; all zero when nothing is granted.
- out_valid_o  output  1  output stage holds a beat.
- out_ready_i  input  1  downstream accepts the beat.
- out_data_o  output  DataWidth  registered beat data.
- out_last_o  output  1  registered last flag.
- out_src_o  output  SrcWidth  registered index of the requester that produced the beat.

Behaviour:
- Reset (rst_i=1 at an edge):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0.
  - Priority pointer ptr=0; state=ARB; lock cleared.
  - Reset mid-packet drops the lock without emitting anything.
  - Reset has priority over every other event.
- Load enable: load_en = !out_valid_o || out_ready_i. The output stage accepts a new beat in the same cycle it is drained, giving full throughput with no bubble.
- ARB state:
  - Winner = first i with req_valid_i[i]=1, searching ptr, ptr+1, …, NumReq-1, 0, …, ptr-1 (modulo NumReq).
  - gnt_o = one-hot of the winner, combinational; 0 if no valid.
  - req_ready_o = gnt_o & {NumReq{load_en}}.
- LOCKED state (owner L):
  - gnt_o = one-hot(L) regardless of req_valid_i[L]; all other requesters are blocked.
  - req_ready_o[L] = load_en; all other ready bits are 0.
  - If L deasserts valid mid-packet, the arbiter stalls; gnt_o stays on L.
- Accept: a handshake occurs when req_valid_i[g] && req_ready_o[g] for the granted g. On that edge:
  - out_data_o <= req_data_i slice g; out_last_o <= req_last_i[g]; out_src_o <= g; out_valid_o <= 1.
  - ptr <= (g+1) mod NumReq, updated on every accepted beat, so it is fair per beat in ARB and ends up past the owner after the packet.
  - If req_last_i[g]=0, go to LOCKED with L=g, or stay LOCKED.
  - If req_last_i[g]=1, go to ARB.
- No accept and out_ready_i=1 while out_valid_o=1: out_valid_o <= 0; data, last and src hold their values.
- Output stage stability: while out_valid_o=1 and out_ready_i=0, all out_* registers are stable.
- Latency: a beat is visible on out_* exactly 1 cycle after its accepting edge.
- Request contract:
  - Requesters must hold data, last and valid stable until accepted.
  - The arbiter never drops or duplicates a beat.
- Single-beat packet (last=1 on the first beat): no lock entered.
- All valids low in ARB: gnt_o=0, ptr unchanged.
- ptr wrap: winner NumReq-1 → ptr=0.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, all valids 0 → out_valid_o=0, gnt_o=0, req_ready_o=0, out_data_o=0, out_src_o=0.
- Fairness, NumReq=4, all four valid with last=1, data 0xA0+i, out_ready_i=1 → out_src_o sequence 0,1,2,3,0,1 on consecutive cycles; out_data_o 0xA0,0xA1,0xA2,0xA3; one beat per cycle.
- Packet lock: req1 sends 3 beats (last on the 3rd) while req0 and req2 are continuously valid → out_src_o=1,1,1, then 2, then 0; gnt_o stays 4'b0010 during the packet.
- Backpressure: out_ready_i=0 for 5 cycles with out_valid_o=1 → out_data_o stable, all req_ready_o=0; releasing out_ready_i with a new valid waiting → new beat appears the next cycle, no gap.
- Stall inside packet: req3 sends its first beat (last=0), then deasserts valid for 3 cycles while req0 is valid → gnt_o=4'b1000, req_ready_o[0]=0 throughout; req3 resumes with last=1 → next winner is req0.
- Reset mid-packet: req2 locked after 1 beat, rst_i pulsed for 1 cycle → state ARB, ptr=0, out_valid_o=0; with req0 and req2 both valid, req0 wins.
